// File: rtl/uart_pkt_rx_if.sv
// Byte/CRC-tap inputs from the UART receiver and the framed packet outputs.
// The upstream side (receiver or bench) uses master; the framer uses slave.
interface uart_pkt_rx_if;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       crc_din;
    logic       crc_en;
    logic [7:0] out_data;
    logic       out_valid;
    logic       pkt_end;
    logic       pkt_good;
    logic [1:0] err_code;
    logic [7:0] pkt_len;
    logic [7:0] err_count;

    modport master (
        output rx_data, rx_ready, crc_din, crc_en,
        input  out_data, out_valid, pkt_end, pkt_good, err_code, pkt_len, err_count
    );

    modport slave (
        input  rx_data, rx_ready, crc_din, crc_en,
        output out_data, out_valid, pkt_end, pkt_good, err_code, pkt_len, err_count
    );
endinterface

// File: rtl/uart_pkt_rx.sv
// Packet framer behind the UART receiver: sync 0xA5, LEN, payload, CRC16 (hi first).
// Streams payload bytes and issues one registered verdict strobe per packet.
module uart_pkt_rx #(
    parameter int MAXLEN  = 64,
    parameter int TIMEOUT = 1200
) (
    input  logic          clk,
    input  logic          reset,
    uart_pkt_rx_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        PAYLOAD,
        CRC_HI,
        CRC_LO
    } state_t;

    localparam int            TW        = $clog2(TIMEOUT + 1);
    localparam logic [7:0]    MAXLEN_B  = 8'(MAXLEN);
    localparam logic [TW-1:0] TIMER_END = TW'(TIMEOUT - 1);

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_CRC     = 2'd1;
    localparam logic [1:0] ERR_LENGTH  = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    state_t        r_state;
    state_t        w_nextState;

    logic [TW-1:0] r_timer;
    logic [15:0]   r_crc;
    logic [7:0]    r_crcHi;
    logic [7:0]    r_remain;

    logic [7:0]    r_outData;
    logic          r_outValid;
    logic          r_pktEnd;
    logic          r_pktGood;
    logic [1:0]    r_errCode;
    logic [7:0]    r_pktLen;
    logic [7:0]    r_errCount;

    logic          w_syncSeen;
    logic          w_latchLen;
    logic          w_payload;
    logic          w_latchHi;
    logic          w_endPulse;
    logic          w_good;
    logic [1:0]    w_errCode;
    logic          w_timeout;
    logic          w_crcStep;
    logic          w_fb;
    logic [15:0]   w_crcShift;

    // A byte strobe in the expiry cycle takes priority over the timeout.
    assign w_timeout = (r_state != IDLE) && !bus.rx_ready && (r_timer == TIMER_END);

    assign w_crcStep  = bus.crc_en && ((r_state == LEN) || (r_state == PAYLOAD));
    assign w_fb       = r_crc[15] ^ bus.crc_din;
    assign w_crcShift = {r_crc[14:0], 1'b0} ^ (w_fb ? 16'h1021 : 16'h0000);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_syncSeen  = 1'b0;
        w_latchLen  = 1'b0;
        w_payload   = 1'b0;
        w_latchHi   = 1'b0;
        w_endPulse  = 1'b0;
        w_good      = 1'b0;
        w_errCode   = ERR_NONE;

        case (r_state)
            IDLE: begin
                if (bus.rx_ready && (bus.rx_data == 8'hA5)) begin
                    w_syncSeen  = 1'b1;
                    w_nextState = LEN;
                end
            end
            LEN: begin
                if (bus.rx_ready) begin
                    w_latchLen = 1'b1;
                    if (bus.rx_data > MAXLEN_B) begin
                        w_endPulse  = 1'b1;
                        w_errCode   = ERR_LENGTH;
                        w_nextState = IDLE;
                    end else if (bus.rx_data == 8'd0) begin
                        w_nextState = CRC_HI;
                    end else begin
                        w_nextState = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (bus.rx_ready) begin
                    w_payload = 1'b1;
                    if (r_remain == 8'd1) begin
                        w_nextState = CRC_HI;
                    end
                end
            end
            CRC_HI: begin
                if (bus.rx_ready) begin
                    w_latchHi   = 1'b1;
                    w_nextState = CRC_LO;
                end
            end
            CRC_LO: begin
                if (bus.rx_ready) begin
                    w_endPulse  = 1'b1;
                    w_nextState = IDLE;
                    if ({r_crcHi, bus.rx_data} == r_crc) begin
                        w_good = 1'b1;
                    end else begin
                        w_errCode = ERR_CRC;
                    end
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase

        if (w_timeout) begin
            w_nextState = IDLE;
            w_endPulse  = 1'b1;
            w_good      = 1'b0;
            w_errCode   = ERR_TIMEOUT;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_timer  <= '0;
            r_crc    <= 16'hFFFF;
            r_crcHi  <= 8'd0;
            r_remain <= 8'd0;
        end else begin
            if (bus.rx_ready || (r_state == IDLE) || w_timeout) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + 1'b1;
            end

            // Only LEN and payload bits feed the CRC; sync and CRC bytes never do.
            if (w_syncSeen) begin
                r_crc <= 16'hFFFF;
            end else if (w_crcStep) begin
                r_crc <= w_crcShift;
            end

            if (w_latchHi) begin
                r_crcHi <= bus.rx_data;
            end

            if (w_latchLen) begin
                r_remain <= bus.rx_data;
            end else if (w_payload) begin
                r_remain <= r_remain - 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_outData  <= 8'd0;
            r_outValid <= 1'b0;
            r_pktEnd   <= 1'b0;
            r_pktGood  <= 1'b0;
            r_errCode  <= ERR_NONE;
            r_pktLen   <= 8'd0;
            r_errCount <= 8'd0;
        end else begin
            r_outValid <= w_payload;
            r_pktEnd   <= w_endPulse;
            r_pktGood  <= w_endPulse && w_good;
            r_errCode  <= w_endPulse ? w_errCode : ERR_NONE;

            if (w_payload) begin
                r_outData <= bus.rx_data;
            end

            if (w_latchLen) begin
                r_pktLen <= bus.rx_data;
            end

            if (w_endPulse && !w_good && (r_errCount != 8'hFF)) begin
                r_errCount <= r_errCount + 8'd1;
            end
        end
    end

    assign bus.out_data  = r_outData;
    assign bus.out_valid = r_outValid;
    assign bus.pkt_end   = r_pktEnd;
    assign bus.pkt_good  = r_pktGood;
    assign bus.err_code  = r_errCode;
    assign bus.pkt_len   = r_pktLen;
    assign bus.err_count = r_errCount;

endmodule

// File: tb/tb_uart_pkt_rx.sv
// Directed bench for uart_pkt_rx: serial CRC bits then a byte strobe per byte,
// hand-computed verdicts checked with immediate assertions.
module tb_uart_pkt_rx;

    localparam int MAXLEN  = 64;
    localparam int TIMEOUT = 1200;

    logic clk = 1'b0;
    logic reset;

    uart_pkt_rx_if bus ();

    uart_pkt_rx #(
        .MAXLEN  (MAXLEN),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int validSeen   = 0;
    int endSeen     = 0;

    logic [7:0] payload[$];

    // Mid-cycle monitor counting output strobes, used to prove absence of strobes.
    always @(negedge clk) begin
        if (bus.out_valid === 1'b1) validSeen++;
        if (bus.pkt_end === 1'b1) endSeen++;
    end

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutputBit(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic checkOutputCount(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs == exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] crcByte(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        logic        fb;
        r = c;
        for (int i = 0; i < 8; i++) begin
            fb = r[15] ^ b[i];
            r  = {r[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        return r;
    endfunction

    // Eight CRC-tap bits LSB first, then the byte strobe; returns 1 time unit after its edge.
    task automatic applyStimulus(input logic [7:0] b);
        for (int i = 0; i < 8; i++) begin
            bus.crc_en  = 1'b1;
            bus.crc_din = b[i];
            @(posedge clk);
            #1;
            bus.crc_en  = 1'b0;
        end
        bus.rx_data  = b;
        bus.rx_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rx_ready = 1'b0;
    endtask

    task automatic sendPacket(input bit corruptCrc);
        logic [15:0] c;
        logic [7:0]  len;
        len = 8'(payload.size());
        c   = crcByte(16'hFFFF, len);
        foreach (payload[k]) c = crcByte(c, payload[k]);
        if (corruptCrc) c = c ^ 16'h0001;
        applyStimulus(8'hA5);
        applyStimulus(len);
        foreach (payload[k]) begin
            applyStimulus(payload[k]);
            checkOutputBit($sformatf("outValid[%0d]", k), bus.out_valid, 1'b1);
            checkOutput($sformatf("outData[%0d]", k), bus.out_data, payload[k]);
        end
        applyStimulus(c[15:8]);
        checkOutputBit("noValidOnCrcHi", bus.out_valid, 1'b0);
        applyStimulus(c[7:0]);
    endtask

    task automatic checkVerdict(input string tag, input logic good, input logic [1:0] code,
                                input logic [7:0] errCount);
        checkOutputBit({tag, ".pktEnd"}, bus.pkt_end, 1'b1);
        checkOutputBit({tag, ".pktGood"}, bus.pkt_good, good);
        checkOutput({tag, ".errCode"}, 8'(bus.err_code), 8'(code));
        checkOutput({tag, ".errCount"}, bus.err_count, errCount);
        @(posedge clk);
        #1;
        checkOutputBit({tag, ".pktEndDrops"}, bus.pkt_end, 1'b0);
    endtask

    initial begin
        int validBefore;
        int endBefore;
        int n;

        reset        = 1'b1;
        bus.rx_data  = 8'd0;
        bus.rx_ready = 1'b0;
        bus.crc_din  = 1'b0;
        bus.crc_en   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst.outData", bus.out_data, 8'd0);
        checkOutputBit("rst.outValid", bus.out_valid, 1'b0);
        checkOutputBit("rst.pktEnd", bus.pkt_end, 1'b0);
        checkOutputBit("rst.pktGood", bus.pkt_good, 1'b0);
        checkOutput("rst.errCode", 8'(bus.err_code), 8'd0);
        checkOutput("rst.pktLen", bus.pkt_len, 8'd0);
        checkOutput("rst.errCount", bus.err_count, 8'd0);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        $display("[TB] zero-length packet with correct CRC");
        validBefore = validSeen;
        applyStimulus(8'hA5);
        applyStimulus(8'h00);
        applyStimulus(8'hE1);
        applyStimulus(8'hF0);
        checkOutput("empty.pktLen", bus.pkt_len, 8'd0);
        checkVerdict("empty", 1'b1, 2'd0, 8'd0);
        checkOutputCount("empty.noValid", validSeen - validBefore, 0);

        $display("[TB] zero-length packet with bad CRC");
        applyStimulus(8'hA5);
        applyStimulus(8'h00);
        applyStimulus(8'hE1);
        applyStimulus(8'hF1);
        checkVerdict("badCrc", 1'b0, 2'd1, 8'd1);

        $display("[TB] noise then two-byte packet");
        validBefore = validSeen;
        endBefore   = endSeen;
        applyStimulus(8'h3C);
        applyStimulus(8'h5A);
        repeat (3) @(posedge clk);
        #1;
        checkOutputCount("noise.noValid", validSeen - validBefore, 0);
        checkOutputCount("noise.noEnd", endSeen - endBefore, 0);
        checkOutput("noise.pktLenHeld", bus.pkt_len, 8'd0);
        payload = '{8'h11, 8'h22};
        sendPacket(1'b0);
        checkOutput("two.pktLen", bus.pkt_len, 8'd2);
        checkVerdict("two", 1'b1, 2'd0, 8'd1);
        checkOutputCount("two.validCount", validSeen - validBefore, 2);

        $display("[TB] sync byte value carried as payload");
        payload = '{8'hA5};
        sendPacket(1'b0);
        checkVerdict("a5data", 1'b1, 2'd0, 8'd1);

        $display("[TB] length above MAXLEN");
        applyStimulus(8'hA5);
        applyStimulus(8'h41);
        checkOutput("len.pktLen", bus.pkt_len, 8'h41);
        checkOutputBit("len.noValid", bus.out_valid, 1'b0);
        checkVerdict("len", 1'b0, 2'd2, 8'd2);
        applyStimulus(8'hA5);
        applyStimulus(8'h00);
        applyStimulus(8'hE1);
        applyStimulus(8'hF0);
        checkVerdict("afterLen", 1'b1, 2'd0, 8'd2);

        $display("[TB] length exactly MAXLEN");
        payload.delete();
        for (int k = 0; k < MAXLEN; k++) payload.push_back(8'(k * 7 + 3));
        validBefore = validSeen;
        sendPacket(1'b0);
        checkOutput("max.pktLen", bus.pkt_len, 8'd64);
        checkVerdict("max", 1'b1, 2'd0, 8'd2);
        checkOutputCount("max.validCount", validSeen - validBefore, MAXLEN);

        $display("[TB] inter-byte timeout");
        applyStimulus(8'hA5);
        applyStimulus(8'h03);
        applyStimulus(8'h11);
        checkOutput("to.outData", bus.out_data, 8'h11);
        n = 0;
        while ((n < 2 * TIMEOUT) && (bus.pkt_end !== 1'b1)) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutputCount("to.cycles", n, TIMEOUT);
        checkVerdict("to", 1'b0, 2'd3, 8'd3);
        applyStimulus(8'hA5);
        applyStimulus(8'h00);
        applyStimulus(8'hE1);
        applyStimulus(8'hF0);
        checkVerdict("afterTo", 1'b1, 2'd0, 8'd3);

        $display("[TB] reset mid-payload");
        applyStimulus(8'hA5);
        applyStimulus(8'h03);
        applyStimulus(8'h22);
        checkOutputBit("midRst.validBefore", bus.out_valid, 1'b1);
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("midRst.outData", bus.out_data, 8'd0);
        checkOutput("midRst.pktLen", bus.pkt_len, 8'd0);
        checkOutput("midRst.errCount", bus.err_count, 8'd0);
        endBefore = endSeen;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (TIMEOUT + 20) @(posedge clk);
        #1;
        checkOutputCount("midRst.noEnd", endSeen - endBefore, 0);
        applyStimulus(8'hA5);
        applyStimulus(8'h00);
        applyStimulus(8'hE1);
        applyStimulus(8'hF0);
        checkVerdict("afterRst", 1'b1, 2'd0, 8'd0);

        $display("[TB] error counter saturation");
        for (int p = 0; p < 260; p++) begin
            applyStimulus(8'hA5);
            applyStimulus(8'h41);
            if (p == 253) checkOutput("sat.at254", bus.err_count, 8'd254);
            if (p == 254) checkOutput("sat.at255", bus.err_count, 8'd255);
        end
        checkOutput("sat.final", bus.err_count, 8'd255);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_pkt_rx.md
Name: uart_pkt_rx

Overview:
- Packet framer and controller that sits directly behind the 1 Mbaud UART receiver.
- Consumes the receiver's byte strobe and its per-bit serial CRC tap.
- Frames packets as: sync 0xA5, LEN, LEN payload bytes, CRC16 (high byte first). Runs the serial CRC-16 engine internally and decides when it resets and when it accumulates.
- Streams payload bytes downstream, then reports a one-cycle verdict per packet.

Parameters:
- MAXLEN, 64: largest accepted LEN value, 1..255.
- TIMEOUT, 1200: clk cycles allowed between bytes inside a packet (100 us at 12 MHz).

Ports:
- clk  in  1  system clock, 12 MHz
- reset  in  1  asynchronous, active-high reset
- rx_data  in  8  received byte; valid when rx_ready is high
- rx_ready  in  1  one-cycle strobe per received byte
- crc_din  in  1  serial bit currently being received
- crc_en  in  1  one-cycle strobe per received data bit; always precedes that byte's rx_ready
- out_data  out  8  payload byte
- out_valid  out  1  one-cycle strobe per payload byte
- pkt_end  out  1  one-cycle strobe: packet finished or aborted
- pkt_good  out  1  qualifies pkt_end: 1 = CRC ok
- err_code  out  2  qualifies pkt_end: 0 none, 1 crc, 2 length, 3 timeout
- pkt_len  out  8  LEN of the current/last packet; held until the next LEN byte
- err_count  out  8  total aborted/bad packets, saturating at 255

Behaviour:
- Reset (async): all outputs 0, state IDLE, crc = 16'hFFFF, timer 0.
- States: IDLE, LEN, PAYLOAD, CRC_HI, CRC_LO. All transitions occur on an rx_ready cycle, except timeout.
- IDLE:
  - rx_ready with rx_data == 0xA5: crc <= 16'hFFFF, go to LEN.
  - Any other byte is dropped silently.
- LEN:
  - rx_ready latches pkt_len <= rx_data and a payload downcounter.
  - LEN > MAXLEN: abort with err_code 2, go to IDLE.
  - LEN == 0: go to CRC_HI.
  - Otherwise: go to PAYLOAD.
- PAYLOAD:
  - Each rx_ready: out_data <= rx_data and out_valid = 1 on the next cycle (latency 1, registered).
  - After the LEN-th byte, go to CRC_HI.
- CRC_HI: rx_ready latches the high byte, go to CRC_LO.
- CRC_LO:
  - rx_ready compares {crc_hi, rx_data} against crc, then goes to IDLE.
  - Next cycle: pkt_end = 1, with pkt_good = 1 / err_code 0 on match, or pkt_good = 0 / err_code 1 on mismatch.
- CRC update:
  - Applies only on crc_en cycles while state is LEN or PAYLOAD, so LEN and payload bits are covered; sync and CRC bytes are not.
  - Bits arrive LSB-first per byte. Non-reflected CCITT: fb = crc[15] ^ crc_din; crc <= {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 0).
  - Because every crc_en pulse for a byte precedes its rx_ready, the state at the time of crc_en is the byte's own state.
- Timeout:
  - Timer clears on every rx_ready and increments each cycle in non-IDLE states.
  - On reaching TIMEOUT: abort with err_code 3, go to IDLE.
  - rx_ready in the same cycle as expiry wins: byte accepted, timer cleared.
- Abort:
  - pkt_end = 1, pkt_good = 0, registered one cycle after the triggering event.
  - Payload bytes already streamed are not retracted; downstream discards them on a bad verdict.
- err_count increments on every pkt_end with pkt_good = 0 and holds at 255.
- 0xA5 seen inside LEN, PAYLOAD or CRC states is treated as data; there is no resync.
- Reset mid-packet: immediate return to IDLE with outputs cleared; no pkt_end is generated.
- pkt_end, out_valid and pkt_good are low on all cycles other than those specified above.

Test Plan:
- Bytes A5 00 E1 F0 -> pkt_len = 0, no out_valid, one pkt_end with pkt_good = 1, err_code 0, err_count 0.
- Bytes A5 00 E1 F1 -> pkt_end, pkt_good = 0, err_code 1, err_count = 1.
- Noise 3C 5A, then A5 02 11 22 plus correct CRC from the bench model -> out_valid exactly twice with 0x11 then 0x22, each one cycle after rx_ready; pkt_good = 1; noise produces no output.
- A5 41 with MAXLEN = 64 -> pkt_end after the LEN byte with err_code 2; following A5 00 E1 F0 -> good packet.
- A5 03 11, then line idle for 1200 clk -> pkt_end with err_code 3 exactly TIMEOUT cycles after the last rx_ready; state returns to IDLE.
- Reset asserted mid-payload -> outputs 0 asynchronously, no pkt_end. Separately, force 260 bad packets -> err_count saturates at 255.
